// File: rtl/fp16_add_engine_if.sv
// fp16_add_engine_if: start/done handshake plus byte-wide data-memory bus.
// master = engine (drives done, mem_addr, mem_wr_en, mem_wr_data); slave = memory/host side.
interface fp16_add_engine_if;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (
    input  start, mem_rd_data,
    output done, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    output start, mem_rd_data,
    input  done, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/fp16_add_engine.sv
// fp16_add_engine: reads two FP16 operands from memory, adds (truncating), writes the sum.
// Ports: clk, reset (sync, active-high), bus (master modport). Option macro: FP16_SUB_EN.
module fp16_add_engine #(
  parameter logic [7:0] BASE_ADDR = 8'd128
) (
  input logic               clk,
  input logic               reset,
  fp16_add_engine_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, RDL,
    ALIGN, ADD, NORM, WR0, WR1, DONE
  } state_t;

  state_t      state_q;
  logic [15:0] op1_q, op2_q;
  logic [10:0] ma_q, mb_q;
  logic [5:0]  exp_q;
  logic        sign_q, inf_q, sub_q;
  logic [11:0] sum_q;
  logic [7:0]  res_lo_q;
  logic        done_q, wr_en_q;
  logic [7:0]  addr_q, wdata_q;

  assign bus.done        = done_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wdata_q;

  logic [4:0]  e1f, e2f;
  logic [5:0]  e1, e2, diff, exp_d;
  logic [10:0] m1, m2, mb_raw, ma_d, mb_d;
  logic        swap, sign_d, inf_d, sub_d;

  always_comb begin
    e1f    = op1_q[14:10];
    e2f    = op2_q[14:10];
    e1     = (e1f == 5'd0) ? 6'd1 : {1'b0, e1f};
    e2     = (e2f == 5'd0) ? 6'd1 : {1'b0, e2f};
    m1     = {|e1f, op1_q[9:0]};
    m2     = {|e2f, op2_q[9:0]};
    // larger magnitude goes to the "a" lane
    swap   = op2_q[14:0] > op1_q[14:0];
    exp_d  = swap ? e2 : e1;
    diff   = swap ? (e2 - e1) : (e1 - e2);
    ma_d   = swap ? m2 : m1;
    mb_raw = swap ? m1 : m2;
    mb_d   = (diff >= 6'd12) ? 11'd0 : (mb_raw >> diff);
    inf_d  = (&e1f) | (&e2f);
`ifdef FP16_SUB_EN
    sub_d  = op1_q[15] ^ op2_q[15];
    sign_d = swap ? op2_q[15] : op1_q[15];
`else
    sub_d  = 1'b0;
    sign_d = op1_q[15];
`endif
  end

  logic [11:0] sum_d;

  always_comb begin
    sum_d = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                  : ({1'b0, ma_q} + {1'b0, mb_q});
  end

  logic [10:0] mn;
  logic [5:0]  en;
  logic [15:0] res_d;
`ifdef FP16_SUB_EN
  logic [5:0]  lz, sh;
`endif

  always_comb begin
    mn = sum_q[10:0];
    en = exp_q;
`ifdef FP16_SUB_EN
    lz = 6'd11;
    for (int i = 0; i <= 10; i++)
      if (sum_q[i]) lz = 6'(10 - i);
    sh = lz;
    // never shift below effective exponent 1 (denormal floor)
    if (sh > exp_q - 6'd1) sh = exp_q - 6'd1;
`endif
    if (sum_q[11]) begin
      mn = sum_q[11:1];
      en = exp_q + 6'd1;
    end
`ifdef FP16_SUB_EN
    else begin
      mn = sum_q[10:0] << sh;
      en = exp_q - sh;
    end
`endif
    if (inf_q || en >= 6'd31)
      res_d = {sign_q, 5'h1F, 10'h000};
    else if (sub_q && sum_q == 12'd0)
      res_d = 16'h0000;
    else
      res_d = {sign_q, mn[10] ? en[4:0] : 5'd0, mn[9:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      inf_q    <= 1'b0;
      sub_q    <= 1'b0;
      sum_q    <= '0;
      res_lo_q <= '0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (!bus.start) begin
          state_q <= RD0;
          addr_q  <= BASE_ADDR;
        end
        RD0: begin
          state_q <= RD1;
          addr_q  <= BASE_ADDR + 8'd1;
        end
        RD1: begin
          op1_q[15:8] <= bus.mem_rd_data;
          state_q     <= RD2;
          addr_q      <= BASE_ADDR + 8'd2;
        end
        RD2: begin
          op1_q[7:0] <= bus.mem_rd_data;
          state_q    <= RD3;
          addr_q     <= BASE_ADDR + 8'd3;
        end
        RD3: begin
          op2_q[15:8] <= bus.mem_rd_data;
          state_q     <= RDL;
        end
        RDL: begin
          op2_q[7:0] <= bus.mem_rd_data;
          state_q    <= ALIGN;
        end
        ALIGN: begin
          ma_q    <= ma_d;
          mb_q    <= mb_d;
          exp_q   <= exp_d;
          sign_q  <= sign_d;
          inf_q   <= inf_d;
          sub_q   <= sub_d;
          state_q <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          state_q <= NORM;
        end
        NORM: begin
          res_lo_q <= res_d[7:0];
          wr_en_q  <= 1'b1;
          addr_q   <= BASE_ADDR + 8'd4;
          wdata_q  <= res_d[15:8];
          state_q  <= WR0;
        end
        WR0: begin
          addr_q  <= BASE_ADDR + 8'd5;
          wdata_q <= res_lo_q;
          state_q <= WR1;
        end
        WR1: begin
          wr_en_q <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          // first DONE cycle always raises done; later cycles wait for start
          if (!done_q) begin
            done_q <= 1'b1;
          end else if (bus.start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_add_engine.sv
// tb_fp16_add_engine: directed vector table plus hand-written corner sequences.
// Memory model is a synchronous-read byte RAM driven through the slave side of the bus.
module tb_fp16_add_engine;
  localparam logic [7:0] B = 8'd128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp16_add_engine_if bus();

  fp16_add_engine #(.BASE_ADDR(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b);
    poke(B,        a[15:8]);
    poke(B + 8'd1, a[7:0]);
    poke(B + 8'd2, b[15:8]);
    poke(B + 8'd3, b[7:0]);
  endtask

  task automatic run_op(input string name, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] want,
                        input bit toggle, input int hold);
    int lat;
    int wr;
    load(a, b);
    poke(B + 8'd4, 8'h00);
    poke(B + 8'd5, 8'h00);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    lat = -1;
    wr  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (toggle && c == 3) bus.start = 1'b1;
      if (bus.mem_wr_en) wr++;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    check({name, " result"}, {mem[B + 8'd4], mem[B + 8'd5]}, want);
    check({name, " latency"}, 16'(lat), 16'd11);
    check({name, " writes"}, 16'(wr), 16'd2);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, " done held"}, {15'd0, bus.done}, 16'd1);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check({name, " done drop"}, {15'd0, bus.done}, 16'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] want;
  } vec_t;

  vec_t vt [14];

  initial begin
    int wr;
    int dn;
    vt[0]  = '{"same_1A04",  16'h1A04, 16'h1A04, 16'h1E04};
    vt[1]  = '{"shift2",     16'h4A10, 16'h4204, 16'h4B91};
    vt[2]  = '{"shift2_sw",  16'h4204, 16'h4A10, 16'h4B91};
    vt[3]  = '{"diff11",     16'h3C00, 16'h1000, 16'h3C00};
    vt[4]  = '{"diff12",     16'h3C00, 16'h0C00, 16'h3C00};
    vt[5]  = '{"zero_plus",  16'h0000, 16'h3C00, 16'h3C00};
    vt[6]  = '{"saturate",   16'h7BFF, 16'h7BFF, 16'h7C00};
    vt[7]  = '{"inf_in",     16'h7C00, 16'h3C00, 16'h7C00};
    vt[8]  = '{"denorm_up",  16'h0200, 16'h0200, 16'h0400};
    vt[9]  = '{"denorm",     16'h0100, 16'h0100, 16'h0200};
    vt[10] = '{"neg_neg",    16'hC000, 16'hC000, 16'hC400};
`ifdef FP16_SUB_EN
    vt[11] = '{"mixed",      16'h4200, 16'hBC00, 16'h4000};
    vt[12] = '{"mixed_sw",   16'hBC00, 16'h4200, 16'h4000};
    vt[13] = '{"cancel",     16'h3C00, 16'hBC00, 16'h0000};
`else
    vt[11] = '{"mixed",      16'h4200, 16'hBC00, 16'h4400};
    vt[12] = '{"mixed_sw",   16'hBC00, 16'h4200, 16'hC400};
    vt[13] = '{"cancel",     16'h3C00, 16'hBC00, 16'h4000};
`endif

    reset     = 1'b1;
    bus.start = 1'b1;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst done",   {15'd0, bus.done},      16'd0);
    check("rst wr_en",  {15'd0, bus.mem_wr_en}, 16'd0);
    check("rst addr",   {8'd0, bus.mem_addr},   16'd0);
    check("rst wdata",  {8'd0, bus.mem_wr_data}, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op(vt[i].name, vt[i].a, vt[i].b, vt[i].want, 1'b0, 0);

    run_op("sat_hold", 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b0, 3);
    run_op("start_glitch", 16'h1A04, 16'h1A04, 16'h1E04, 1'b1, 0);

    load(16'h1A04, 16'h1A04);
    poke(B + 8'd4, 8'hAA);
    poke(B + 8'd5, 8'h55);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    wr = 0;
    dn = 0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_wr_en) wr++;
      if (bus.done) dn++;
      if (c == 1) reset = 1'b0;
    end
    check("abort writes", 16'(wr), 16'd0);
    check("abort done",   16'(dn), 16'd0);
    check("abort mem",    {mem[B + 8'd4], mem[B + 8'd5]}, 16'hAA55);

    run_op("after_abort", 16'h4A10, 16'h4204, 16'h4B91, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fp16_add_engine.md
FP16_ADD_ENGINE -- requirements
Module: fp16_add_engine

Interface
REQ-001 Parameter: BASE_ADDR, 128, byte address of operand 1 MSB; operand 2 at BASE_ADDR+2, result at BASE_ADDR+4.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request-hold; 1 = hold/idle, 0 = run one addition.
REQ-005 Port: done  output  1  result written; held until start returns to 1.
REQ-006 Port: mem_addr  output  8  data-memory byte address.
REQ-007 Port: mem_rd_data  input  8  read data; valid one cycle after mem_addr (synchronous read).
REQ-008 Port: mem_wr_en  output  1  write strobe, one byte per cycle.
REQ-009 Port: mem_wr_data  output  8  write data.

Function
REQ-010 Operands: IEEE-754 half precision, byte order MSB at even address: flt1 = {mem[B],mem[B+1]}, flt2 = {mem[B+2],mem[B+3]}; result to {mem[B+4],mem[B+5]}.
REQ-011 FSM states: IDLE, RD0, RD1, RD2, RD3, RDL, ALIGN, ADD, NORM, WR0, WR1, DONE; one state per cycle, no stalls.
REQ-012 IDLE -> RD0 when start==0 is sampled; RD0..RD3 drive B..B+3; RDL captures byte B+3.
REQ-013 done rises exactly 11 rising edges after the edge sampling start==0 in IDLE.
REQ-014 mem_wr_en high only in WR0 (addr B+4, result[15:8]) and WR1 (addr B+5, result[7:0]); exactly two write cycles per operation.
REQ-015 DONE: done=1, held; DONE -> IDLE when start==1 is sampled; done drops the same edge.
REQ-016 start changes outside IDLE/DONE are ignored; an operation always completes.
REQ-017 Hidden bit = |exp field; exp field 0 uses effective exponent 1 (denormal).
REQ-018 Align: smaller-exponent mantissa right-shifted by the exponent difference, shifted-out bits truncated; difference >= 12 contributes 0.
REQ-019 Same signs: 12-bit sum; carry -> shift right 1 (truncate), exponent+1; result sign = common sign.
REQ-020 Result exponent reaching 31 saturates to infinity {sign,5'h1F,10'h0}; inputs with exp field 31 give the same.
REQ-021 Normalised result with hidden bit 0 and exponent 1 is encoded with exp field 0.
REQ-022 No rounding anywhere; all lost bits are truncated.

Reset
REQ-023 On reset: state=IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, internal registers 0.
REQ-024 Reset mid-operation aborts immediately; no further writes occur; the result bytes are left unmodified if reset is asserted before WR0.

Configuration
REQ-025 Macro FP16_SUB_EN defined: different signs perform magnitude subtraction (larger minus smaller); sign = sign of larger magnitude; NORM left-shifts in one cycle (priority encode) down to effective exponent 1; exact cancellation gives 0x0000.
REQ-026 Macro FP16_SUB_EN undefined: different signs add magnitudes as in REQ-019 and take the sign of flt1; latency is identical either way.

Verification
REQ-027 flt1=flt2=0x1A04, start 1->0 -> mem[132]=0x1E, mem[133]=0x04; done exactly 11 cycles after start is sampled low.
REQ-028 flt1=0x4A10, flt2=0x4204 -> result 0x4B91 (shift by 2, no carry).
REQ-029 flt1=0x3C00, flt2=0x1000 (difference 11) -> 0x3C00; flt1=0x0000, flt2=0x3C00 -> 0x3C00.
REQ-030 flt1=flt2=0x7BFF -> 0x7C00 (saturation); done held while start=0, drops on the edge start=1 is sampled.
REQ-031 reset asserted in RD2 with mem[132..133] preset to 0xAA55 -> done stays 0, mem_wr_en never high, memory still 0xAA55; next run completes normally.
REQ-032 flt1=0x4200, flt2=0xBC00 -> 0x4000 with FP16_SUB_EN, 0x4400 without; with FP16_SUB_EN, flt1=0x3C00, flt2=0xBC00 -> 0x0000.
